// File: rtl/vit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vit_pkg
// Description : Shared constants, FSM state type and traceback helper for the
//               K=3 rate-1/2 Viterbi frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vit_pkg;

    localparam int NUM_STATES = 4;
    localparam int SYM_W      = 2;
    localparam int DEC_W      = 4;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TB    = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } ctrl_state_t;

    // Predecessor of state s = {u_t, u_t-1}, given the stored decision bit u_t-2.
    function automatic logic [1:0] prev_state(input logic [1:0] s, input logic d);
        return {s[0], d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vit_ctrl_if
// Description : Symbol-in and decoded-bit-out handshake bundle of vit_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface vit_ctrl_if;
    import vit_pkg::*;

    logic [SYM_W-1:0] sym_in;
    logic             sym_valid;
    logic             sym_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_last;
    logic             bit_ready;

    modport master (
        output sym_in, sym_valid, bit_ready,
        input  sym_ready, bit_out, bit_valid, bit_last
    );

    modport slave (
        input  sym_in, sym_valid, bit_ready,
        output sym_ready, bit_out, bit_valid, bit_last
    );

endinterface
`default_nettype wire

// File: rtl/vit_tb_unit.sv
`default_nettype none
// ============================================================================
// Module      : vit_tb_unit
// Description : Traceback state register; selects the decision bit of the
//               current state and exposes the decoded bit u_t = state[1].
// Revision    : 1.0 - initial release
// ============================================================================
module vit_tb_unit
    import vit_pkg::*;
(
    input  wire             clk,
    input  wire             rst,
    input  wire             step,
    input  wire             init,
    input  wire [DEC_W-1:0] surv_rdata,
    output logic            u_bit
);

    localparam int c_sw = $clog2(NUM_STATES);

    logic [c_sw-1:0] r_tb_state;
    logic            w_dec;

    assign w_dec = surv_rdata[r_tb_state];
    assign u_bit = r_tb_state[c_sw-1];

    // Zero-tail termination: traceback always starts from state 0.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            r_tb_state <= '0;
        end else if (step) begin
            r_tb_state <= prev_state(r_tb_state, w_dec);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vit_ctrl
// Description : Viterbi frame sequencer: symbol acquisition with ACS/survivor
//               strobes, traceback over survivor memory, in-order bit output.
// Revision    : 1.0 - initial release
// ============================================================================
module vit_ctrl
    import vit_pkg::*;
#(
    parameter  int FRAME_LEN = 32,
    parameter  int TAIL      = 2,
    localparam int AW        = $clog2(FRAME_LEN)
) (
    input  wire              clk,
    input  wire              rst,
    vit_ctrl_if.slave        io,
    output logic [SYM_W-1:0] bmu_sym,
    output logic             acs_en,
    output logic             acs_init,
    output logic             surv_we,
    output logic [AW-1:0]    surv_waddr,
    output logic             surv_rd,
    output logic [AW-1:0]    surv_raddr,
    input  wire  [DEC_W-1:0] surv_rdata,
    output logic             busy
);

    localparam logic [AW-1:0] c_last_sym = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] c_last_bit = AW'(FRAME_LEN - TAIL - 1);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_nxt;
    logic [AW-1:0]        r_sym_cnt;
    logic [AW-1:0]        r_rd_cnt;
    logic [AW-1:0]        r_out_cnt;
    logic [AW-1:0]        r_step_addr;
    logic                 r_rd_pend;
    logic [FRAME_LEN-1:0] r_dec_buf;
    logic                 w_tb_init;
    logic                 w_bit_hs;
    logic                 w_u_bit;

    assign io.sym_ready = (r_state == ACQ);
    assign bmu_sym      = io.sym_in;
    assign acs_en       = io.sym_valid & io.sym_ready;
    assign acs_init     = acs_en & (r_sym_cnt == '0);
    assign surv_we      = acs_en;
    assign surv_waddr   = r_sym_cnt;
    assign surv_rd      = (r_state == TB);
    assign surv_raddr   = r_rd_cnt;
    assign io.bit_valid = (r_state == OUT);
    assign io.bit_out   = io.bit_valid & r_dec_buf[r_out_cnt];
    assign io.bit_last  = io.bit_valid & (r_out_cnt == c_last_bit);
    assign busy         = (r_state == TB) || (r_state == OUT);
    assign w_tb_init    = acs_en & (r_sym_cnt == c_last_sym);
    assign w_bit_hs     = io.bit_valid & io.bit_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACQ:     if (w_tb_init) w_state_nxt = TB;
            TB:      if (r_rd_cnt == '0) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = OUT;
            OUT:     if (w_bit_hs && io.bit_last) w_state_nxt = ACQ;
            default: w_state_nxt = ACQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACQ;
            r_sym_cnt   <= '0;
            r_rd_cnt    <= '0;
            r_out_cnt   <= '0;
            r_step_addr <= '0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Survivor data arrives one cycle after the read; remember which address it belongs to.
            r_rd_pend   <= surv_rd;
            r_step_addr <= r_rd_cnt;
            case (r_state)
                ACQ: begin
                    if (w_tb_init) begin
                        r_rd_cnt <= c_last_sym;
                    end else if (acs_en) begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end
                end
                TB: begin
                    if (r_rd_cnt != '0) begin
                        r_rd_cnt <= r_rd_cnt - 1'b1;
                    end
                end
                DRAIN: r_out_cnt <= '0;
                OUT: begin
                    if (w_bit_hs) begin
                        if (io.bit_last) begin
                            r_sym_cnt <= '0;
                        end else begin
                            r_out_cnt <= r_out_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_rd_pend) begin
            r_dec_buf[r_step_addr] <= w_u_bit;
        end
    end

    vit_tb_unit u_tb_unit (
        .clk        (clk),
        .rst        (rst),
        .step       (r_rd_pend),
        .init       (w_tb_init),
        .surv_rdata (surv_rdata),
        .u_bit      (w_u_bit)
    );

endmodule
`default_nettype wire

// File: tb/tb_vit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vit_ctrl
// Description : Scoreboard bench for vit_ctrl with FRAME_LEN=8, TAIL=2 and a
//               1-cycle-latency survivor memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vit_ctrl;
    import vit_pkg::*;

    localparam int FL = 8;
    localparam int TL = 2;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vit_ctrl_if vif ();

    logic [1:0]    bmu_sym;
    logic          acs_en, acs_init, surv_we, surv_rd, busy;
    logic [AW-1:0] surv_waddr, surv_raddr;
    logic [3:0]    surv_rdata = 4'd0;
    logic [3:0]    mem [FL];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bit_hs = 0;
    int last_hs_cyc = 0;
    bit wait_first = 1'b0;
    bit stalled = 1'b0;
    logic held_bit, held_last;
    logic [1:0] exp_q [$];
    logic [1:0] e;
    logic [AW-1:0] exp_waddr = '0;
    logic [AW-1:0] exp_raddr = AW'(FL - 1);

    vit_ctrl #(.FRAME_LEN(FL), .TAIL(TL)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (vif),
        .bmu_sym    (bmu_sym),
        .acs_en     (acs_en),
        .acs_init   (acs_init),
        .surv_we    (surv_we),
        .surv_waddr (surv_waddr),
        .surv_rd    (surv_rd),
        .surv_raddr (surv_raddr),
        .surv_rdata (surv_rdata),
        .busy       (busy)
    );

    always @(posedge clk) begin
        cyc++;
        if (surv_rd) surv_rdata <= mem[surv_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: strobes, addresses, latency, stall stability and scoreboard pops.
    always @(negedge clk) begin
        check("acs_en_hs", acs_en, vif.sym_valid & vif.sym_ready);
        check("surv_we", surv_we, acs_en);
        check("bmu_sym", bmu_sym, vif.sym_in);
        if (surv_rd || vif.bit_valid) begin
            check("blocked_ready", vif.sym_ready, 1'b0);
            check("busy", busy, 1'b1);
        end
        if (acs_en) begin
            check("surv_waddr", surv_waddr, exp_waddr);
            check("acs_init", acs_init, exp_waddr == '0);
            if (exp_waddr == AW'(FL - 1)) begin
                last_hs_cyc = cyc;
                wait_first  = 1'b1;
                exp_waddr   = '0;
            end else begin
                exp_waddr = exp_waddr + 1'b1;
            end
        end else begin
            check("acs_init_idle", acs_init, 1'b0);
        end
        if (surv_rd) begin
            check("surv_raddr", surv_raddr, exp_raddr);
            exp_raddr = (exp_raddr == '0) ? AW'(FL - 1) : exp_raddr - 1'b1;
        end
        if (vif.bit_valid) begin
            if (wait_first) begin
                check("first_bit_latency", cyc - last_hs_cyc, 10);
                wait_first = 1'b0;
            end
            if (stalled) begin
                check("stall_bit_out", vif.bit_out, held_bit);
                check("stall_bit_last", vif.bit_last, held_last);
            end
            if (vif.bit_ready) begin
                bit_hs++;
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_bit: got bit_valid handshake, expected none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_out", vif.bit_out, e[0]);
                    check("bit_last", vif.bit_last, e[1]);
                end
            end else begin
                stalled   = 1'b1;
                held_bit  = vif.bit_out;
                held_last = vif.bit_last;
            end
        end else begin
            stalled = 1'b0;
        end
        if (rst) begin
            exp_waddr  = '0;
            exp_raddr  = AW'(FL - 1);
            wait_first = 1'b0;
            stalled    = 1'b0;
        end
    end

    // Survivor decisions from the encoder state path {u_t, u_t-1}; entry for s_t holds u_t-2.
    task automatic load_mem(input logic [7:0] msg, input logic [3:0] pad);
        for (int t = 0; t < FL; t++) begin
            logic [1:0] s;
            logic       d;
            s = {msg[t], (t > 0) ? msg[t-1] : 1'b0};
            d = (t > 1) ? msg[t-2] : 1'b0;
            mem[t]    = pad;
            mem[t][s] = d;
        end
    endtask

    task automatic send_sym(input logic [1:0] s);
        int n = 0;
        vif.sym_in    = s;
        vif.sym_valid = 1'b1;
        @(negedge clk);
        while (!vif.sym_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!vif.sym_ready) begin
            total++;
            bad++;
            $display("FAIL sym_timeout: sym_ready got %0b expected 1", vif.sym_ready);
        end
        @(posedge clk);
        #1;
        vif.sym_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] msg, input int gap, input bit push);
        if (push) begin
            for (int i = 0; i < FL - TL; i++) exp_q.push_back({i == FL - TL - 1, msg[i]});
        end
        for (int i = 0; i < FL; i++) begin
            send_sym(2'(i * 3));
            if (gap > 0 && (i % 3) == 1) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !vif.sym_ready || vif.bit_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got %0d bits pending, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        vif.sym_in    = 2'd0;
        vif.sym_valid = 1'b0;
        vif.bit_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sym_ready", vif.sym_ready, 1'b1);
        check("rst_acs_en", acs_en, 1'b0);
        check("rst_acs_init", acs_init, 1'b0);
        check("rst_surv_we", surv_we, 1'b0);
        check("rst_surv_rd", surv_rd, 1'b0);
        check("rst_surv_raddr", surv_raddr, 3'd0);
        check("rst_surv_waddr", surv_waddr, 3'd0);
        check("rst_bit_out", vif.bit_out, 1'b0);
        check("rst_bit_valid", vif.bit_valid, 1'b0);
        check("rst_bit_last", vif.bit_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // All-zero decisions
        load_mem(8'b0000_0000, 4'b0000);
        send_frame(8'b0000_0000, 0, 1'b1);
        wait_idle();

        // Path decode of 1,0,1,1,0,0 + tail
        load_mem(8'b0000_1101, 4'b1010);
        send_frame(8'b0000_1101, 0, 1'b1);
        wait_idle();

        // Backpressure: symbol gaps plus a 3-cycle output stall
        load_mem(8'b0001_0110, 4'b0101);
        send_frame(8'b0001_0110, 2, 1'b1);
        base = bit_hs;
        n = 0;
        while (bit_hs < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_out", bit_hs >= base + 2, 1'b1);
        @(posedge clk);
        #1;
        vif.bit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vif.bit_ready = 1'b1;
        wait_idle();

        // Blocked input: second frame offered while the first is still in TB/OUT
        load_mem(8'b0000_1101, 4'b1010);
        send_frame(8'b0000_1101, 0, 1'b1);
        send_frame(8'b0000_1101, 0, 1'b1);
        wait_idle();

        // Reset on the 3rd TB cycle, then a clean frame
        load_mem(8'b0011_1011, 4'b0011);
        send_frame(8'b0011_1011, 0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!surv_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_saw_tb", surv_rd, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_surv_rd", surv_rd, 1'b0);
        check("rst_mid_sym_ready", vif.sym_ready, 1'b1);
        check("rst_mid_bit_valid", vif.bit_valid, 1'b0);
        check("rst_mid_raddr", surv_raddr, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        load_mem(8'b0010_0111, 4'b1111);
        send_frame(8'b0010_0111, 0, 1'b1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
